instr_prefetch_buffer: RTL and testbench
========================================

# instr_prefetch_buffer

Instruction prefetch buffer between the core's fetch stage and the instruction memory port. It issues sequential word fetches using the req/gnt/rvalid protocol and keeps up to two transactions outstanding. Returned instructions go into a DEPTH-entry FIFO. The fetch stage pops one instruction per valid/ready handshake, and a branch flushes the buffer, discards in-flight responses and restarts fetching at the target.

## Interface
- WORD_WIDTH, 32: instruction and address width.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_i  input  1  fetch enable from the core; when low, no new request is issued.
- branch_i  input  1  one-cycle redirect pulse; also used to load the start PC after reset.
- branch_addr_i  input  WORD_WIDTH  redirect target; bits [1:0] ignored (forced to 0).
- valid_o  output  1  FIFO head holds a valid instruction.
- ready_i  input  1  consumer accepts the head this cycle.
- rdata_o  output  WORD_WIDTH  head instruction.
- addr_o  output  WORD_WIDTH  PC of the head instruction.
- instr_req_o  output  1  memory request.
- instr_addr_o  output  WORD_WIDTH  request address.
- instr_gnt_i  input  1  request accepted this cycle.
- instr_rvalid_i  input  1  response data valid this cycle.
- instr_rdata_i  input  WORD_WIDTH  response data.

## Operation
- Internal state:
  - fetch_addr: next address to request.
  - out_addr: PC of the FIFO head.
  - FIFO storage with count (0..DEPTH).
  - outstanding: granted but unanswered requests, 0..2.
  - discard: responses to drop, 0..2.
  - FSM over request phase.
- FSM IDLE:
  - instr_req_o=0.
  - Go to REQ when req_i=1 and outstanding<2 and count+outstanding-discard<DEPTH (credit; a response can never overflow the FIFO).
  - Credit is evaluated combinationally, so instr_req_o rises in the same cycle the condition holds.
- FSM REQ:
  - instr_req_o=1, instr_addr_o=fetch_addr.
  - Both are held stable until instr_gnt_i=1, regardless of req_i or branch_i.
  - On gnt: outstanding+1, fetch_addr+4 (wraps modulo 2^WORD_WIDTH).
  - After gnt, return to IDLE, or stay in REQ if credit still holds (back-to-back issue).
- Response handling:
  - On instr_rvalid_i, outstanding-1.
  - If discard>0: discard-1 and the data is dropped.
  - Otherwise the data is pushed to the FIFO.
- Pop: valid_o && ready_i && !branch_i gives count-1 and out_addr+4.
- Branch (branch_i=1):
  - FIFO count cleared.
  - out_addr ← {branch_addr_i[W-1:2],2'b00}.
  - fetch_addr ← the same value, unless a request is pending ungranted in REQ. In that case the in-progress address is kept, its response is marked for discard, and fetch_addr loads the target as soon as gnt occurs.
  - discard ← every outstanding response not yet returned, including one granted in the branch cycle. A response with rvalid in the branch cycle is dropped.
- Simultaneous push and pop: both apply; count unchanged.
- valid_o = (count≠0) && !branch_i.
- rdata_o and addr_o are don't-care when valid_o=0.
- Memory protocol errors (rvalid with outstanding=0) are ignored: no push and no counter underflow.

## Timing
- Reset values:
  - instr_req_o=0, instr_addr_o=0, valid_o=0, rdata_o=0, addr_o=0.
  - fetch_addr=0, out_addr=0, count=0, outstanding=0, discard=0.
  - FSM=IDLE.
- Reset asserted mid-transaction clears everything immediately. Responses arriving after reset is released are treated as protocol errors and ignored.
- Minimum latency from request to use:
  - gnt in cycle N.
  - rvalid no earlier than N+1.
  - Push at the end of the rvalid cycle; valid_o at the next cycle (no bypass).
- Throughput: one instruction per cycle sustained when memory grants every cycle and returns with fixed latency ≤ 1.
- Branch-to-first-request: instr_req_o for the target is asserted in the cycle after branch_i, unless an earlier request is still waiting for gnt.

## Test plan
- **Basic fetch.**
  - Stimulus: rst pulse, branch_i with branch_addr_i=0x100, req_i=1, memory gnt same cycle, rvalid next cycle, ready_i=1.
  - Required: instr_addr_o sequence 0x100,0x104,0x108; addr_o/rdata_o match the memory; first valid_o two cycles after the first gnt.
- **Backpressure / full.**
  - Stimulus: ready_i=0, DEPTH=4.
  - Required: exactly 4 requests issued, then instr_req_o stays 0. Raising ready_i for one pop lets exactly one new request issue.
- **Branch with two responses in flight.**
  - Stimulus: two outstanding responses when branch_i fires to 0x200.
  - Required: both responses are dropped; the first valid_o has addr_o=0x200.
- **Branch while ungranted.**
  - Stimulus: instr_req_o held at 0x10C for 3 cycles of gnt=0, branch_i to 0x400 in cycle 2.
  - Required: instr_addr_o stays 0x10C until gnt, next request is 0x400, and no 0x10C data appears on rdata_o.
- **Simultaneous events.**
  - Stimulus: push+pop in the same cycle at count=2, then branch_i together with ready_i and rvalid.
  - Required: count remains 2 after the push+pop. In the branch cycle valid_o=0, no pop occurs, and the rvalid data is dropped.
- **Wrap and async reset.**
  - Stimulus: branch to 0xFFFFFFFC, then assert rst mid-burst.
  - Required: the next request address is 0x00000000. Outputs go to reset values without waiting for a clock edge, and late rvalid pulses after reset release produce no valid_o.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetcher, two requests in flight, DEPTH-entry FIFO
module instr_prefetch_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_addr_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic [WORD_WIDTH-1:0] addr_o,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // REQ means a request is on the bus and has not been granted yet
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [WORD_WIDTH-1:0] fetch_addr;
  logic [WORD_WIDTH-1:0] out_addr;
  logic [WORD_WIDTH-1:0] pend_target;
  logic                  pend_branch;
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [1:0]            outstanding;
  logic [1:0]            discard;

  logic [WORD_WIDTH-1:0] target;
  logic [CW:0]           in_use;
  logic                  credit;
  logic                  grant;
  logic                  resp;
  logic                  push;
  logic                  pop;
  logic [1:0]            outstanding_nxt;
  logic [1:0]            discard_nxt;
  logic                  unused_addr_lsb;

  assign target          = {branch_addr_i[WORD_WIDTH-1:2], 2'b00};
  assign unused_addr_lsb = ^branch_addr_i[1:0];

  // FIFO slots already promised: a granted response must always find room
  assign in_use = (CW+1)'(count) + (CW+1)'(outstanding) - (CW+1)'(discard);
  assign credit = req_i && !branch_i && (outstanding != 2'd2) && (in_use < (CW+1)'(DEPTH));

  assign instr_req_o  = !rst && ((state == REQ) || credit);
  assign instr_addr_o = fetch_addr;
  assign grant        = instr_req_o && instr_gnt_i;
  assign resp         = instr_rvalid_i && (outstanding != 2'd0);
  assign push         = resp && (discard == 2'd0) && !branch_i;

  assign valid_o = (count != '0) && !branch_i;
  assign pop     = valid_o && ready_i;
  assign rdata_o = (count != '0) ? mem[rd_ptr] : '0;
  assign addr_o  = out_addr;

  assign outstanding_nxt = outstanding + 2'(grant) - 2'(resp);

  always_comb begin
    discard_nxt = discard;
    if (resp && (discard != 2'd0)) discard_nxt = discard_nxt - 2'd1;
    // the request caught ungranted by a branch is dropped once it is granted
    if (grant && pend_branch) discard_nxt = discard_nxt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr_rdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      out_addr    <= '0;
      pend_target <= '0;
      pend_branch <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= (instr_req_o && !instr_gnt_i) ? REQ : IDLE;
      outstanding <= outstanding_nxt;
      if (branch_i) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        out_addr <= target;
        discard  <= outstanding_nxt;
        if ((state == REQ) && !instr_gnt_i) begin
          pend_branch <= 1'b1;
          pend_target <= target;
        end else begin
          pend_branch <= 1'b0;
          fetch_addr  <= target;
        end
      end else begin
        discard <= discard_nxt;
        count   <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + PW'(1);
          out_addr <= out_addr + WORD_WIDTH'(4);
        end
        if (grant) begin
          fetch_addr  <= pend_branch ? pend_target : fetch_addr + WORD_WIDTH'(4);
          pend_branch <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - scoreboard bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_i;
  logic         branch_i;
  logic [W-1:0] branch_addr_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] rdata_o;
  logic [W-1:0] addr_o;
  logic         instr_req_o;
  logic [W-1:0] instr_addr_o;
  logic         instr_gnt_i;
  logic         instr_rvalid_i;
  logic [W-1:0] instr_rdata_i;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.WORD_WIDTH(W), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i)
  );

  typedef struct { logic [W-1:0] addr; logic good; } grant_t;
  typedef struct { logic [W-1:0] addr; logic [W-1:0] data; } instr_t;

  grant_t       inflight[$];
  instr_t       sb[$];
  logic [W-1:0] grant_log[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           pops;
  logic         gnt_en;
  logic         resp_en;
  logic         stale_next;
  logic [W-1:0] exp_next;
  logic [W-1:0] held_addr;
  logic [W-1:0] first_pop;

  function automatic logic [W-1:0] mem_data(input logic [W-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5a00_00a5;
  endfunction

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // one clock: memory response at negedge, observe, then model update
  task automatic tick();
    grant_t       g;
    instr_t       e;
    logic         got_resp;
    logic         resp_good;
    logic         granted;
    logic [W-1:0] resp_addr;
    logic [W-1:0] cur_exp;
    @(negedge clk);
    instr_gnt_i = gnt_en;
    got_resp = 1'b0;
    resp_good = 1'b0;
    resp_addr = '0;
    if (resp_en && inflight.size() != 0) begin
      g = inflight.pop_front();
      got_resp = 1'b1;
      resp_good = g.good;
      resp_addr = g.addr;
    end
    instr_rvalid_i = got_resp;
    instr_rdata_i  = got_resp ? mem_data(resp_addr) : 32'hdead_beef;
    #1;
    check_val("valid_o", W'(valid_o), W'(sb.size() != 0 && !branch_i));
    if (valid_o && ready_i && sb.size() != 0) begin
      e = sb.pop_front();
      check_val("pop_addr", addr_o, e.addr);
      check_val("pop_data", rdata_o, e.data);
      if (pops == 0) first_pop = addr_o;
      pops++;
    end
    cur_exp = stale_next ? held_addr : exp_next;
    granted = instr_req_o && instr_gnt_i;
    if (instr_req_o) check_val("req_addr", instr_addr_o, cur_exp);
    if (granted) begin
      grant_log.push_back(instr_addr_o);
      if (branch_i || stale_next) begin
        g.addr = instr_addr_o;
        g.good = 1'b0;
        stale_next = 1'b0;
      end else begin
        g.addr = exp_next;
        g.good = 1'b1;
        exp_next = exp_next + 32'd4;
      end
      inflight.push_back(g);
    end
    if (got_resp && resp_good && !branch_i) begin
      e.addr = resp_addr;
      e.data = mem_data(resp_addr);
      sb.push_back(e);
    end
    if (branch_i) begin
      if (instr_req_o && !granted) begin
        held_addr = cur_exp;
        stale_next = 1'b1;
      end
      exp_next = {branch_addr_i[W-1:2], 2'b00};
      foreach (inflight[i]) inflight[i].good = 1'b0;
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_branch(input logic [W-1:0] a);
    branch_i = 1'b1;
    branch_addr_i = a;
    tick();
    branch_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},   W'(instr_req_o), '0);
    check_val({tag, "_iaddr"}, instr_addr_o, '0);
    check_val({tag, "_valid"}, W'(valid_o), '0);
    check_val({tag, "_rdata"}, rdata_o, '0);
    check_val({tag, "_addr"},  addr_o, '0);
  endtask

  initial begin
    rst = 1'b1;
    req_i = 1'b0;
    branch_i = 1'b0;
    branch_addr_i = '0;
    ready_i = 1'b0;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i = '0;
    gnt_en = 1'b0;
    resp_en = 1'b0;
    stale_next = 1'b0;
    exp_next = '0;
    held_addr = '0;
    first_pop = '0;
    pops = 0;
    #3;
    check_reset_outputs("reset");
    run(2);
    rst = 1'b0;
    run(1);

    // basic fetch, low address bits of the target ignored
    req_i = 1'b1; gnt_en = 1'b1; resp_en = 1'b1; ready_i = 1'b1;
    grant_log.delete(); pops = 0; first_pop = '0;
    do_branch(32'h0000_0103);
    run(8);
    check_val("basic_nreq", W'(grant_log.size() >= 3), W'(1));
    if (grant_log.size() >= 3) begin
      check_val("basic_req0", grant_log[0], 32'h100);
      check_val("basic_req1", grant_log[1], 32'h104);
      check_val("basic_req2", grant_log[2], 32'h108);
    end
    check_val("basic_first_pop", first_pop, 32'h100);
    req_i = 1'b0;
    run(4);

    // backpressure: FIFO fills, then one pop frees one request
    ready_i = 1'b0; req_i = 1'b1;
    do_branch(32'h100);
    grant_log.delete();
    run(12);
    check_val("full_nreq", W'(grant_log.size()), 32'd4);
    check_val("full_req_low", W'(instr_req_o), '0);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    run(6);
    check_val("full_one_more", W'(grant_log.size()), 32'd5);
    ready_i = 1'b1; req_i = 1'b0;
    run(8);

    // branch with two responses outstanding
    req_i = 1'b1; resp_en = 1'b0;
    do_branch(32'h180);
    run(4);
    check_val("inflight_two", W'(inflight.size()), 32'd2);
    do_branch(32'h200);
    resp_en = 1'b1; pops = 0; first_pop = '0;
    run(10);
    check_val("br2_first_pop", first_pop, 32'h200);
    req_i = 1'b0;
    run(4);

    // branch while a request waits for grant
    gnt_en = 1'b0; req_i = 1'b1;
    do_branch(32'h10c);
    grant_log.delete();
    tick();
    check_val("ungnt_req_c1", W'(instr_req_o), W'(1));
    check_val("ungnt_addr_c1", instr_addr_o, 32'h10c);
    do_branch(32'h400);
    check_val("ungnt_req_c2", W'(instr_req_o), W'(1));
    check_val("ungnt_addr_c2", instr_addr_o, 32'h10c);
    tick();
    check_val("ungnt_addr_c3", instr_addr_o, 32'h10c);
    gnt_en = 1'b1; pops = 0; first_pop = '0;
    run(8);
    check_val("ungnt_nreq", W'(grant_log.size() >= 2), W'(1));
    if (grant_log.size() >= 2) begin
      check_val("ungnt_g0", grant_log[0], 32'h10c);
      check_val("ungnt_g1", grant_log[1], 32'h400);
    end
    check_val("ungnt_first_pop", first_pop, 32'h400);
    req_i = 1'b0;
    run(4);

    // push+pop at count 2, then branch with ready and rvalid together
    ready_i = 1'b0; req_i = 1'b1;
    do_branch(32'h300);
    run(3);
    ready_i = 1'b1;
    tick();
    req_i = 1'b0; resp_en = 1'b0;
    tick();
    check_val("pp_valid", W'(valid_o), W'(1));
    check_val("pp_head", addr_o, 32'h308);
    resp_en = 1'b1;
    check_val("pp_resp_ready", W'(inflight.size()), 32'd1);
    do_branch(32'h500);
    req_i = 1'b1; pops = 0; first_pop = '0;
    run(6);
    check_val("sim_first_pop", first_pop, 32'h500);
    req_i = 1'b0;
    run(4);

    // address wrap, then asynchronous reset mid-burst
    ready_i = 1'b0; req_i = 1'b1;
    grant_log.delete();
    do_branch(32'hffff_fffc);
    run(3);
    check_val("wrap_nreq", W'(grant_log.size() >= 2), W'(1));
    if (grant_log.size() >= 2) check_val("wrap_req1", grant_log[1], 32'h0);
    resp_en = 1'b0;
    run(1);
    check_val("pre_rst_valid", W'(valid_o), W'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    foreach (inflight[i]) inflight[i].good = 1'b0;
    sb.delete();
    stale_next = 1'b0;
    exp_next = '0;
    req_i = 1'b0;
    run(2);
    rst = 1'b0;
    resp_en = 1'b1;
    ready_i = 1'b1;
    run(4);
    check_val("late_resp_valid", W'(valid_o), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
